// File: rtl/pipe_ctl.sv
// rtl/pipe_ctl.sv - pipeline stall/flush/redirect/interrupt controller
module pipe_ctl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [31:0] INT_BASE     = 32'hFFFF_FF00
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        pc_set_i,
  input  logic [31:0] pc_target_i,
  input  logic [31:0] wb_pc_i,
  input  logic        mem_stall_i,
  input  logic        hazard_i,
  input  logic        if_stall_i,
  input  logic        halt_i,
  input  logic        int_req_i,
  input  logic [3:0]  int_vec_i,
  output logic [4:0]  stall_o,
  output logic [4:0]  flush_o,
  output logic        pc_load_o,
  output logic [31:0] pc_load_addr_o,
  output logic        int_ack_o,
  output logic [31:0] epc_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_INT   = 2'd2,
    ST_HALT  = 2'd3
  } state_e;

  localparam logic [3:0] FLUSH_LOAD = 4'(FLUSH_CYCLES);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        pc_load_q, pc_load_d;
  logic [31:0] addr_q, addr_d;
  logic        ack_q, ack_d;
  logic [31:0] epc_q, epc_d;
  logic [31:0] int_addr;

  // Vector table entry is 4 bytes per interrupt; the sum wraps modulo 2^32.
  assign int_addr = INT_BASE + {26'b0, int_vec_i, 2'b00};

  // State register: all controller state and registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q   <= ST_RUN;
      cnt_q     <= 4'd0;
      pc_load_q <= 1'b0;
      addr_q    <= 32'd0;
      ack_q     <= 1'b0;
      epc_q     <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pc_load_q <= pc_load_d;
      addr_q    <= addr_d;
      ack_q     <= ack_d;
      epc_q     <= epc_d;
    end
  end

  // Next-state logic: one event per cycle in RUN, highest priority first;
  // the interrupt load/ack/epc are set on entry so they are visible in INT.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pc_load_d = 1'b0;
    addr_d    = addr_q;
    ack_d     = 1'b0;
    epc_d     = epc_q;
    case (state_q)
      ST_RUN: begin
        if (mem_stall_i) begin
          state_d = ST_RUN;
        end else if (pc_set_i) begin
          state_d   = ST_FLUSH;
          cnt_d     = FLUSH_LOAD;
          pc_load_d = 1'b1;
          addr_d    = pc_target_i;
        end else if (int_req_i) begin
          state_d   = ST_INT;
          pc_load_d = 1'b1;
          addr_d    = int_addr;
          ack_d     = 1'b1;
          epc_d     = wb_pc_i;
        end else if (halt_i) begin
          state_d = ST_HALT;
        end
      end
      ST_FLUSH: begin
        // A memory stall freezes the squash window so its length is in
        // advancing cycles, not wall-clock cycles.
        if (!mem_stall_i) begin
          if (cnt_q <= 4'd1) begin
            state_d = ST_RUN;
            cnt_d   = 4'd0;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      ST_INT: begin
        state_d = ST_FLUSH;
        cnt_d   = FLUSH_LOAD;
      end
      ST_HALT: begin
        if (int_req_i) begin
          state_d   = ST_INT;
          pc_load_d = 1'b1;
          addr_d    = int_addr;
          ack_d     = 1'b1;
          epc_d     = wb_pc_i;
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Output logic: per-stage hold/bubble from the current state and inputs.
  always_comb begin
    stall_o = 5'b00000;
    flush_o = 5'b00000;
    if (!rst_i) begin
      flush_o = 5'b11111;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (mem_stall_i) begin
            stall_o = 5'b11111;
          end else if (pc_set_i || int_req_i) begin
            flush_o = 5'b01111;
          end else if (halt_i) begin
            stall_o = 5'b00000;
          end else if (hazard_i) begin
            stall_o = 5'b00011;
            flush_o = 5'b00100;
          end else if (if_stall_i) begin
            stall_o = 5'b00001;
            flush_o = 5'b00010;
          end
        end
        ST_FLUSH: begin
          flush_o = 5'b00001;
          if (mem_stall_i) begin
            stall_o = 5'b11111;
          end
        end
        ST_INT: begin
          flush_o = 5'b00001;
        end
        ST_HALT: begin
          stall_o = 5'b11111;
        end
        default: begin
          flush_o = 5'b11111;
        end
      endcase
    end
  end

  assign pc_load_o      = pc_load_q;
  assign pc_load_addr_o = addr_q;
  assign int_ack_o      = ack_q;
  assign epc_o          = epc_q;
  assign state_o        = state_q;

endmodule
